// File: rtl/ring_load_arbiter_if.sv
// Handshake and observation bundle for ring_load_arbiter.
// The master side drives requests; the slave side (the arbiter) returns grants, status and ring state.
interface ring_load_arbiter_if #(
  parameter int W = 5
);
  logic [1:0]   req;
  logic [W-1:0] req_data0;
  logic [W-1:0] req_data1;
  logic [1:0]   gnt;
  logic         busy;
  logic         done;
  logic         err;
  logic [W-1:0] ring_a;
  logic [W-1:0] ring_b;
  logic [W-1:0] ring_c;
  logic [W-1:0] t_out;

  modport master (
    output req, req_data0, req_data1,
    input  gnt, busy, done, err, ring_a, ring_b, ring_c, t_out
  );

  modport slave (
    input  req, req_data0, req_data1,
    output gnt, busy, done, err, ring_a, ring_b, ring_c, t_out
  );
endinterface

// File: rtl/ring_load_arbiter.sv
// Two-requester round-robin loader for a 3-register rotation ring (a, b, c) plus step counter t.
// Define RING_ASSERT_EN to compile in the ring_a != FORBID, one-hot grant and done/busy checks.
module ring_load_arbiter #(
  parameter int W       = 5,
  parameter int FORBID  = 2,
  parameter int STEP    = 2,
  parameter int ROT_CYC = 3
) (
  input logic               clock,
  input logic               reset_n,
  ring_load_arbiter_if.slave bus
);

  localparam int CNT_W = (ROT_CYC > 1) ? $clog2(ROT_CYC) : 1;
  localparam logic [CNT_W-1:0] LAST_ROT = CNT_W'(ROT_CYC - 1);
  localparam logic [W-1:0] FORBID_V = W'(FORBID);
  localparam logic [W-1:0] STEP_V   = W'(STEP);

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    ROTATE
  } state_t;

  state_t           state;
  logic [W-1:0]     ring_a_q;
  logic [W-1:0]     ring_b_q;
  logic [W-1:0]     ring_c_q;
  logic [W-1:0]     t_q;
  logic [W-1:0]     stage;
  logic [CNT_W-1:0] rot_cnt;
  logic             rr_ptr;
  logic             winner;
  logic [1:0]       gnt_q;
  logic             busy_q;
  logic             done_q;
  logic             err_q;

  logic             win;
  logic [W-1:0]     candidate;
  logic [W-1:0]     a_next;

  always_comb begin
    win = 1'b0;
    if (bus.req == 2'b10) begin
      win = 1'b1;
    end else if (bus.req == 2'b11) begin
      win = rr_ptr;
    end
  end

  // Rotation feedback into ring_a; a FORBID candidate is bumped by one so ring_a can never hold it.
  always_comb begin
    candidate = t_q;
    if (ring_b_q == W'(5)) begin
      candidate = W'(5);
    end else if (ring_c_q == W'(1)) begin
      candidate = W'(7);
    end else if (ring_b_q == W'(1)) begin
      candidate = W'(3);
    end
    a_next = (candidate == FORBID_V) ? candidate + W'(1) : candidate;
  end

  // busy covers the rotation only, which keeps the grant pulse (LOAD cycle) and busy disjoint.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      ring_a_q <= W'(1);
      ring_b_q <= W'(5);
      ring_c_q <= W'(7);
      t_q      <= W'(11);
      stage    <= '0;
      rot_cnt  <= '0;
      rr_ptr   <= 1'b0;
      winner   <= 1'b0;
      gnt_q    <= 2'b00;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      gnt_q  <= 2'b00;
      done_q <= 1'b0;
      err_q  <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.req != 2'b00) begin
            gnt_q  <= win ? 2'b10 : 2'b01;
            stage  <= win ? bus.req_data1 : bus.req_data0;
            winner <= win;
            state  <= LOAD;
          end
        end
        LOAD: begin
          if (stage != FORBID_V) begin
            ring_a_q <= stage;
          end else begin
            err_q <= 1'b1;
          end
          rot_cnt <= '0;
          busy_q  <= 1'b1;
          state   <= ROTATE;
        end
        ROTATE: begin
          ring_b_q <= ring_c_q;
          ring_c_q <= ring_a_q;
          ring_a_q <= a_next;
          t_q      <= t_q + STEP_V;
          if (rot_cnt == LAST_ROT) begin
            busy_q <= 1'b0;
            done_q <= 1'b1;
            rr_ptr <= ~winner;
            state  <= IDLE;
          end else begin
            rot_cnt <= rot_cnt + CNT_W'(1);
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign bus.gnt    = gnt_q;
  assign bus.busy   = busy_q;
  assign bus.done   = done_q;
  assign bus.err    = err_q;
  assign bus.ring_a = ring_a_q;
  assign bus.ring_b = ring_b_q;
  assign bus.ring_c = ring_c_q;
  assign bus.t_out  = t_q;

`ifdef RING_ASSERT_EN
  a_ring_safe: assert property (@(posedge clock) disable iff (!reset_n) ring_a_q != FORBID_V);
  a_gnt_onehot: assert property (@(posedge clock) disable iff (!reset_n) $onehot0(gnt_q));
  a_done_not_busy: assert property (@(posedge clock) disable iff (!reset_n) !(done_q && busy_q));
`else
`endif

endmodule

// File: tb/tb_ring_load_arbiter.sv
// Directed bench for ring_load_arbiter: default instance (FORBID=2) plus a FORBID=13 instance.
module tb_ring_load_arbiter;

  logic clock;
  logic reset_n;
  int   checks;
  int   errors;

  ring_load_arbiter_if #(.W(5)) bus ();
  ring_load_arbiter_if #(.W(5)) bus2 ();

  ring_load_arbiter #(.W(5), .FORBID(2), .STEP(2), .ROT_CYC(3)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus)
  );

  ring_load_arbiter #(.W(5), .FORBID(13), .STEP(2), .ROT_CYC(3)) dut2 (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus2)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic apply_reset();
    bus.req        = 2'b00;
    bus.req_data0  = '0;
    bus.req_data1  = '0;
    bus2.req       = 2'b00;
    bus2.req_data0 = '0;
    bus2.req_data1 = '0;
    reset_n = 1'b0;
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
  endtask

  // Drives one request and follows it to its done pulse; hold keeps req asserted after the grant.
  task automatic run_txn(input logic [1:0] r, input logic [4:0] d0, input logic [4:0] d1,
                         input bit hold, output logic [1:0] g, output bit e,
                         output int lat, output bit timed_out);
    bit got;
    int gcyc;
    got = 1'b0;
    gcyc = 0;
    g = 2'b00;
    e = 1'b0;
    lat = -1;
    timed_out = 1'b1;
    bus.req = r;
    bus.req_data0 = d0;
    bus.req_data1 = d1;
    for (int i = 0; i < 30; i++) begin
      @(negedge clock);
      if (bus.gnt != 2'b00 && !got) begin
        got = 1'b1;
        g = bus.gnt;
        gcyc = i;
        if (!hold) bus.req = 2'b00;
      end
      if (bus.err) e = 1'b1;
      if (bus.done) begin
        lat = i - gcyc;
        timed_out = 1'b0;
        break;
      end
    end
    if (!hold) bus.req = 2'b00;
  endtask

  task automatic test_reset();
    apply_reset();
    reset_n = 1'b0;
    #1;
    checks++; if (bus.ring_a !== 5'd1) begin errors++; $display("[TB] FAIL reset_a: got %0d expected 1", bus.ring_a); end
    checks++; if (bus.ring_b !== 5'd5) begin errors++; $display("[TB] FAIL reset_b: got %0d expected 5", bus.ring_b); end
    checks++; if (bus.ring_c !== 5'd7) begin errors++; $display("[TB] FAIL reset_c: got %0d expected 7", bus.ring_c); end
    checks++; if (bus.t_out !== 5'd11) begin errors++; $display("[TB] FAIL reset_t: got %0d expected 11", bus.t_out); end
    checks++; if ({bus.gnt, bus.busy, bus.done, bus.err} !== 5'b00000) begin
      errors++; $display("[TB] FAIL reset_ctl: got %b expected 00000", {bus.gnt, bus.busy, bus.done, bus.err});
    end
    @(negedge clock);
    reset_n = 1'b1;
    repeat (4) @(negedge clock);
    checks++; if ({bus.gnt, bus.busy, bus.ring_a, bus.t_out} !== {2'b00, 1'b0, 5'd1, 5'd11}) begin
      errors++; $display("[TB] FAIL idle_hold: got gnt=%b busy=%b a=%0d t=%0d expected gnt=00 busy=0 a=1 t=11",
                         bus.gnt, bus.busy, bus.ring_a, bus.t_out);
    end
  endtask

  task automatic test_single_load();
    logic [1:0] g;
    bit e;
    bit to;
    int lat;
    int extra;
    apply_reset();
    run_txn(2'b01, 5'd9, 5'd0, 1'b0, g, e, lat, to);
    checks++; if (to) begin errors++; $display("[TB] FAIL single_timeout: got no done expected done"); end
    checks++; if (g !== 2'b01) begin errors++; $display("[TB] FAIL single_gnt: got %b expected 01", g); end
    checks++; if (e !== 1'b0) begin errors++; $display("[TB] FAIL single_err: got %0d expected 0", e); end
    checks++; if (lat !== 4) begin errors++; $display("[TB] FAIL single_latency: got %0d expected 4", lat); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("[TB] FAIL done_busy: got %0d expected 0", bus.busy); end
    checks++; if ({bus.ring_a, bus.ring_b, bus.ring_c, bus.t_out} !== {5'd15, 5'd5, 5'd13, 5'd17}) begin
      errors++; $display("[TB] FAIL single_ring: got a=%0d b=%0d c=%0d t=%0d expected a=15 b=5 c=13 t=17",
                         bus.ring_a, bus.ring_b, bus.ring_c, bus.t_out);
    end
    extra = 0;
    repeat (4) begin
      @(negedge clock);
      if (bus.done) extra++;
    end
    checks++; if (extra !== 0) begin errors++; $display("[TB] FAIL single_done_once: got %0d extra expected 0", extra); end
  endtask

  task automatic test_round_robin();
    logic [1:0] g;
    bit e;
    bit to;
    int lat;
    apply_reset();
    run_txn(2'b11, 5'd9, 5'd10, 1'b1, g, e, lat, to);
    checks++; if (to || g !== 2'b01) begin errors++; $display("[TB] FAIL rr_first: got %b expected 01", g); end
    run_txn(2'b11, 5'd9, 5'd10, 1'b1, g, e, lat, to);
    checks++; if (to || g !== 2'b10) begin errors++; $display("[TB] FAIL rr_second: got %b expected 10", g); end
    run_txn(2'b11, 5'd9, 5'd10, 1'b0, g, e, lat, to);
    checks++; if (to || g !== 2'b01) begin errors++; $display("[TB] FAIL rr_third: got %b expected 01", g); end
  endtask

  task automatic test_forbid_load();
    logic [1:0] g;
    bit e;
    bit to;
    int lat;
    apply_reset();
    run_txn(2'b10, 5'd0, 5'd2, 1'b0, g, e, lat, to);
    checks++; if (to) begin errors++; $display("[TB] FAIL forbid_timeout: got no done expected done"); end
    checks++; if (g !== 2'b10) begin errors++; $display("[TB] FAIL forbid_gnt: got %b expected 10", g); end
    checks++; if (e !== 1'b1) begin errors++; $display("[TB] FAIL forbid_err: got %0d expected 1", e); end
    checks++; if ({bus.ring_a, bus.ring_b, bus.ring_c, bus.t_out} !== {5'd3, 5'd5, 5'd7, 5'd17}) begin
      errors++; $display("[TB] FAIL forbid_ring: got a=%0d b=%0d c=%0d t=%0d expected a=3 b=5 c=7 t=17",
                         bus.ring_a, bus.ring_b, bus.ring_c, bus.t_out);
    end
  endtask

  task automatic test_forbid_param();
    logic [4:0] exp_a [4] = '{5'd9, 5'd5, 5'd14, 5'd15};
    bit got;
    got = 1'b0;
    apply_reset();
    bus2.req = 2'b01;
    bus2.req_data0 = 5'd9;
    for (int i = 0; i < 10 && !got; i++) begin
      @(negedge clock);
      if (bus2.gnt != 2'b00) got = 1'b1;
    end
    bus2.req = 2'b00;
    checks++; if (!got || bus2.gnt !== 2'b01) begin errors++; $display("[TB] FAIL p13_gnt: got %b expected 01", bus2.gnt); end
    if (got) begin
      for (int k = 0; k < 4; k++) begin
        @(negedge clock);
        checks++; if (bus2.ring_a !== exp_a[k]) begin
          errors++; $display("[TB] FAIL p13_a_step%0d: got %0d expected %0d", k, bus2.ring_a, exp_a[k]);
        end
      end
      checks++; if (bus2.done !== 1'b1) begin errors++; $display("[TB] FAIL p13_done: got %0d expected 1", bus2.done); end
      checks++; if ({bus2.ring_b, bus2.ring_c, bus2.t_out} !== {5'd5, 5'd14, 5'd17}) begin
        errors++; $display("[TB] FAIL p13_ring: got b=%0d c=%0d t=%0d expected b=5 c=14 t=17",
                           bus2.ring_b, bus2.ring_c, bus2.t_out);
      end
    end
  endtask

  task automatic test_t_wrap();
    logic [1:0] g;
    bit e;
    bit to;
    int lat;
    bit got;
    apply_reset();
    repeat (3) run_txn(2'b01, 5'd9, 5'd0, 1'b0, g, e, lat, to);
    checks++; if (bus.t_out !== 5'd29) begin errors++; $display("[TB] FAIL wrap_pre_t: got %0d expected 29", bus.t_out); end
    got = 1'b0;
    bus.req = 2'b01;
    bus.req_data0 = 5'd9;
    for (int i = 0; i < 10 && !got; i++) begin
      @(negedge clock);
      if (bus.gnt != 2'b00) got = 1'b1;
    end
    bus.req = 2'b00;
    checks++; if (!got) begin errors++; $display("[TB] FAIL wrap_gnt: got none expected 01"); end
    if (got) begin
      repeat (2) @(negedge clock);
      checks++; if (bus.t_out !== 5'd31) begin errors++; $display("[TB] FAIL wrap_t31: got %0d expected 31", bus.t_out); end
      @(negedge clock);
      checks++; if (bus.t_out !== 5'd1) begin errors++; $display("[TB] FAIL wrap_t1: got %0d expected 1", bus.t_out); end
      @(negedge clock);
      checks++; if (bus.t_out !== 5'd3 || bus.done !== 1'b1) begin
        errors++; $display("[TB] FAIL wrap_end: got t=%0d done=%0d expected t=3 done=1", bus.t_out, bus.done);
      end
    end
  endtask

  task automatic test_reset_mid_rotate();
    bit got;
    int dones;
    got = 1'b0;
    apply_reset();
    bus.req = 2'b01;
    bus.req_data0 = 5'd9;
    for (int i = 0; i < 10 && !got; i++) begin
      @(negedge clock);
      if (bus.gnt != 2'b00) got = 1'b1;
    end
    bus.req = 2'b00;
    checks++; if (!got) begin errors++; $display("[TB] FAIL abort_gnt: got none expected 01"); end
    repeat (2) @(negedge clock);
    checks++; if (bus.busy !== 1'b1) begin errors++; $display("[TB] FAIL abort_busy_pre: got %0d expected 1", bus.busy); end
    #2;
    reset_n = 1'b0;
    #1;
    checks++; if ({bus.ring_a, bus.ring_b, bus.ring_c, bus.t_out, bus.busy} !== {5'd1, 5'd5, 5'd7, 5'd11, 1'b0}) begin
      errors++; $display("[TB] FAIL abort_state: got a=%0d b=%0d c=%0d t=%0d busy=%0d expected a=1 b=5 c=7 t=11 busy=0",
                         bus.ring_a, bus.ring_b, bus.ring_c, bus.t_out, bus.busy);
    end
    dones = 0;
    @(negedge clock);
    reset_n = 1'b1;
    repeat (8) begin
      @(negedge clock);
      if (bus.done) dones++;
    end
    checks++; if (dones !== 0) begin errors++; $display("[TB] FAIL abort_no_done: got %0d expected 0", dones); end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    reset_n = 1'b0;
    bus.req = 2'b00;
    bus.req_data0 = '0;
    bus.req_data1 = '0;
    bus2.req = 2'b00;
    bus2.req_data0 = '0;
    bus2.req_data1 = '0;
    test_reset();
    test_single_load();
    test_round_robin();
    test_forbid_load();
    test_forbid_param();
    test_t_wrap();
    test_reset_mid_rotate();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
